// File: rtl/mul_res_fifo.sv
// Result buffer after the multiplier's last pipeline stage. It queues {res, status}
// pairs, hands them out over valid/ready, and keeps sticky fflags and an overrun flag.
module mul_res_fifo #(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXPO_W+MANT_W:0]   in_res,
  input  logic [4:0]               in_status,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXPO_W+MANT_W:0]   out_res,
  output logic [4:0]               out_status,
  output logic [4:0]               fflags,
  input  logic                     fflags_clr,
  output logic                     overrun,
  output logic [CNT_W-1:0]         count
);

  localparam int RES_W = EXPO_W + MANT_W + 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic [RES_W-1:0] mem_res_q [DEPTH];
  logic [4:0]       mem_st_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       fflags_q, fflags_d;
  logic             overrun_q, overrun_d;

  logic push, pop, drop;

  assign in_ready   = (count_q != CNT_W'(DEPTH));
  assign out_valid  = (count_q != '0);
  assign out_res    = mem_res_q[rd_ptr_q];
  assign out_status = mem_st_q[rd_ptr_q];
  assign fflags     = fflags_q;
  assign overrun    = overrun_q;
  assign count      = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  assign drop = in_valid && !in_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    // Clear first, then OR in this cycle's pop/drop so no event is lost.
    fflags_d  = (fflags_clr ? 5'b0 : fflags_q) | (pop ? out_status : 5'b0);
    overrun_d = (fflags_clr ? 1'b0 : overrun_q) | drop;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      fflags_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      fflags_q  <= fflags_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage has no reset; the pointers alone decide what is live.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_res_q[wr_ptr_q] <= in_res;
      mem_st_q[wr_ptr_q]  <= in_status;
    end
  end

endmodule

// File: tb/tb_mul_res_fifo.sv
// Directed bench for mul_res_fifo: one task per scenario with hand-computed expectations.
module tb_mul_res_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_res;
  logic [4:0]  in_status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [4:0]  out_status;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic        overrun;
  logic [2:0]  count;

  int n_pass  = 0;
  int n_total = 0;

  mul_res_fifo #(.EXPO_W(8), .MANT_W(23), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res), .in_status(in_status),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_status(out_status),
    .fflags(fflags), .fflags_clr(fflags_clr), .overrun(overrun), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_res = '0; in_status = '0;
    out_ready = 1'b0; fflags_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_total++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
    n_total++; if (fflags !== 5'b0) $display("FAIL reset_fflags got %b exp 00000", fflags); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b exp 0", overrun); else n_pass++;
  endtask

  task automatic test_single_push();
    in_valid = 1'b1; in_res = 32'h3F80_0000; in_status = 5'b00001;
    tick();
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1) $display("FAIL single_out_valid got %b exp 1", out_valid); else n_pass++;
    n_total++; if (out_res !== 32'h3F80_0000) $display("FAIL single_out_res got %h exp 3f800000", out_res); else n_pass++;
    n_total++; if (count !== 3'd1) $display("FAIL single_count got %0d exp 1", count); else n_pass++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_total++; if (fflags !== 5'b00001) $display("FAIL single_fflags got %b exp 00001", fflags); else n_pass++;
    n_total++; if (count !== 3'd0) $display("FAIL single_count_after_pop got %0d exp 0", count); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_empty got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_fill_overrun();
    logic [31:0] vals [4];
    vals[0] = 32'h4000_0000; vals[1] = 32'h4040_0000;
    vals[2] = 32'h4080_0000; vals[3] = 32'h40A0_0000;
    in_status = 5'b0;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (in_ready !== 1'b1) $display("FAIL fill_in_ready_%0d got %b exp 1", i, in_ready); else n_pass++;
      in_valid = 1'b1; in_res = vals[i];
      tick();
    end
    n_total++; if (in_ready !== 1'b0) $display("FAIL fill_full_in_ready got %b exp 0", in_ready); else n_pass++;
    n_total++; if (count !== 3'd4) $display("FAIL fill_count got %0d exp 4", count); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL fill_no_overrun_yet got %b exp 0", overrun); else n_pass++;
    in_res = 32'h40C0_0000;
    tick();
    in_valid = 1'b0;
    n_total++; if (overrun !== 1'b1) $display("FAIL fill_overrun got %b exp 1", overrun); else n_pass++;
    n_total++; if (count !== 3'd4) $display("FAIL fill_count_after_drop got %0d exp 4", count); else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (out_res !== vals[i]) $display("FAIL fill_drain_%0d got %h exp %h", i, out_res, vals[i]); else n_pass++;
      tick();
    end
    out_ready = 1'b0;
    n_total++; if (count !== 3'd0) $display("FAIL fill_drained_count got %0d exp 0", count); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL fill_overrun_sticky got %b exp 1", overrun); else n_pass++;
  endtask

  task automatic test_full_pop_push();
    logic [31:0] vals [4];
    vals[0] = 32'h1111_0000; vals[1] = 32'h2222_0000;
    vals[2] = 32'h3333_0000; vals[3] = 32'h4444_0000;
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    n_total++; if (overrun !== 1'b0) $display("FAIL fullpp_clr_overrun got %b exp 0", overrun); else n_pass++;
    n_total++; if (fflags !== 5'b0) $display("FAIL fullpp_clr_fflags got %b exp 00000", fflags); else n_pass++;
    in_status = 5'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_res = vals[i];
      tick();
    end
    in_res = 32'hDEAD_BEEF; out_ready = 1'b1;
    n_total++; if (in_ready !== 1'b0) $display("FAIL fullpp_in_ready got %b exp 0", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    n_total++; if (count !== 3'd3) $display("FAIL fullpp_count got %0d exp 3", count); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL fullpp_overrun got %b exp 1", overrun); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL fullpp_ready_again got %b exp 1", in_ready); else n_pass++;
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      n_total++; if (out_res !== vals[i]) $display("FAIL fullpp_drain_%0d got %h exp %h", i, out_res, vals[i]); else n_pass++;
      tick();
    end
    out_ready = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL fullpp_empty got %b exp 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    in_status = 5'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_res = 32'h5000_0000 + i;
      q.push_back(in_res);
      tick();
    end
    n_total++; if (count !== 3'd2) $display("FAIL b2b_start_count got %0d exp 2", count); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_res = 32'h5000_0002 + k;
      n_total++; if (out_res !== q[0]) $display("FAIL b2b_head_%0d got %h exp %h", k, out_res, q[0]); else n_pass++;
      tick();
      void'(q.pop_front());
      q.push_back(32'h5000_0002 + k);
      n_total++; if (count !== 3'd2) $display("FAIL b2b_count_%0d got %0d exp 2", k, count); else n_pass++;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_total++; if (out_res !== q[0]) $display("FAIL b2b_drain_%0d got %h exp %h", k, out_res, q[0]); else n_pass++;
      tick();
      void'(q.pop_front());
    end
    out_ready = 1'b0;
    n_total++; if (count !== 3'd0) $display("FAIL b2b_end_count got %0d exp 0", count); else n_pass++;
  endtask

  task automatic test_flags();
    logic [4:0] st [4];
    st[0] = 5'b10000; st[1] = 5'b00100; st[2] = 5'b00010; st[3] = 5'b00000;
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_res = 32'h6000_0000 + i; in_status = st[i % 4];
      tick();
    end
    in_valid = 1'b0;
    n_total++; if (overrun !== 1'b1) $display("FAIL flags_overrun_set got %b exp 1", overrun); else n_pass++;
    n_total++; if (fflags !== 5'b0) $display("FAIL flags_none_popped got %b exp 00000", fflags); else n_pass++;
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    n_total++; if (fflags !== 5'b10100) $display("FAIL flags_accum got %b exp 10100", fflags); else n_pass++;
    n_total++; if (out_status !== 5'b00010) $display("FAIL flags_head_status got %b exp 00010", out_status); else n_pass++;
    out_ready = 1'b1; fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    n_total++; if (fflags !== 5'b00010) $display("FAIL flags_clr_pop got %b exp 00010", fflags); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL flags_clr_overrun got %b exp 0", overrun); else n_pass++;
    tick();
    out_ready = 1'b0;
    n_total++; if (fflags !== 5'b00010) $display("FAIL flags_after_zero_pop got %b exp 00010", fflags); else n_pass++;
    n_total++; if (count !== 3'd0) $display("FAIL flags_end_count got %0d exp 0", count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [4:0] st [5];
    st[0] = 5'b00001; st[1] = 5'b00100; st[2] = 5'b0; st[3] = 5'b0; st[4] = 5'b0;
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_res = 32'h7000_0000 + i; in_status = st[i];
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0; in_valid = 1'b1; in_res = 32'h7000_0010; in_status = 5'b0;
    tick();
    n_total++; if (count !== 3'd3) $display("FAIL rmid_pre_count got %0d exp 3", count); else n_pass++;
    n_total++; if (fflags !== 5'b00101) $display("FAIL rmid_pre_fflags got %b exp 00101", fflags); else n_pass++;
    n_total++; if (overrun !== 1'b1) $display("FAIL rmid_pre_overrun got %b exp 1", overrun); else n_pass++;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_res = 32'h7000_0020;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_total++; if (count !== 3'd0) $display("FAIL rmid_count got %0d exp 0", count); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid got %b exp 0", out_valid); else n_pass++;
    n_total++; if (fflags !== 5'b0) $display("FAIL rmid_fflags got %b exp 00000", fflags); else n_pass++;
    n_total++; if (overrun !== 1'b0) $display("FAIL rmid_overrun got %b exp 0", overrun); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready got %b exp 1", in_ready); else n_pass++;
    in_valid = 1'b1; in_res = 32'h7000_0030; in_status = 5'b01000;
    tick();
    in_valid = 1'b0;
    n_total++; if (out_res !== 32'h7000_0030) $display("FAIL rmid_repush_res got %h exp 70000030", out_res); else n_pass++;
    n_total++; if (out_status !== 5'b01000) $display("FAIL rmid_repush_status got %b exp 01000", out_status); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_overrun();
    test_full_pop_push();
    test_back_to_back();
    test_flags();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
